// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK poll controller.
// Holds the FSM state encoding, the LED command prefix and the bit offsets
// of the X/Y/button fields inside the 40-bit DOUT response, plus helpers
// that extract those fields.
package jstk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Upper six bits of the command byte; the low two bits carry the LED value.
  localparam logic [5:0] LED_CMD_PFX = 6'b100000;

  // Field offsets inside DOUT (byte order as shifted out by the PmodJSTK).
  localparam int X_LO = 32;
  localparam int X_HI = 24;
  localparam int Y_LO = 16;
  localparam int Y_HI = 8;
  localparam int BTN  = 0;

  function automatic logic [9:0] x_field(input logic [39:0] d);
    return {d[X_HI +: 2], d[X_LO +: 8]};
  endfunction

  function automatic logic [9:0] y_field(input logic [39:0] d);
    return {d[Y_HI +: 2], d[Y_LO +: 8]};
  endfunction

  function automatic logic [2:0] btn_field(input logic [39:0] d);
    return d[BTN +: 3];
  endfunction

endpackage

// File: rtl/jstk_tick_gen.sv
// Poll-rate tick generator.
// Counts 0..POLL_DIV-1 while enabled and asserts tick during the last count,
// so one tick is produced every POLL_DIV cycles. The count is held at zero
// while disabled, which makes the first tick after enabling land exactly
// POLL_DIV cycles later.
// Ports:
//   CLK  - system clock
//   RST  - synchronous, active-high reset
//   en   - count enable (poll_en)
//   tick - one-cycle pulse on counter wrap
module jstk_tick_gen #(
  parameter int unsigned POLL_DIV = 20_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/jstk_poll_ctrl.sv
// PmodJSTK transaction scheduler.
// Issues sndRec pulses at the programmed poll rate, merges periodic polls
// with host LED-update requests into single SPI transactions, holds the
// command byte stable for the whole transfer, and captures the 40-bit
// response once the transfer window has elapsed.
// Ports:
//   CLK, RST      - clock, synchronous active-high reset
//   poll_en       - enable periodic polling
//   led_req       - one-cycle LED update request, led_val sampled with it
//   dout[39:0]    - response bytes from the PmodJSTK interface
//   snd_rec       - sndRec strobe to the interface (SND_HOLD cycles wide)
//   din[7:0]      - command byte, stable from SEND through CAPTURE
//   busy          - transaction in progress (SEND..CAPTURE)
//   x_pos, y_pos, btn, sample_valid - decoded sample and its update pulse
//   led_ack       - pulse when a transaction carrying a new LED value ends
//   overrun       - sticky: a tick arrived while one was already pending
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a pending tick or LED request
// SEND    | snd_rec high, SND_HOLD cycles
// WAIT    | snd_rec low, XFER_CYCLES cycles for the SPI bytes to land
// CAPTURE | one cycle; sample/ack pulses are high, then back to IDLE
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int unsigned POLL_DIV    = 20_000_000,
  parameter int unsigned SND_HOLD    = 100,
  parameter int unsigned XFER_CYCLES = 200_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        poll_en,
  input  logic        led_req,
  input  logic [1:0]  led_val,
  input  logic [39:0] dout,
  output logic        snd_rec,
  output logic [7:0]  din,
  output logic        busy,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        sample_valid,
  output logic        led_ack,
  output logic        overrun
);

  localparam logic [31:0] HOLD_LD = 32'(SND_HOLD - 1);
  localparam logic [31:0] XFER_LD = 32'(XFER_CYCLES - 1);

  state_t      state;
  logic [31:0] tmr;
  logic        tick;
  logic        tick_pend;
  logic        led_pend;
  logic [1:0]  led_shadow;
  logic        carry_ack;
  logic        start;

  jstk_tick_gen #(
    .POLL_DIV(POLL_DIV)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .en  (poll_en),
    .tick(tick)
  );

  assign start = (state == IDLE) && (tick_pend || led_pend);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      tmr          <= '0;
      tick_pend    <= 1'b0;
      led_pend     <= 1'b0;
      led_shadow   <= 2'b00;
      carry_ack    <= 1'b0;
      snd_rec      <= 1'b0;
      din          <= {LED_CMD_PFX, 2'b00};
      busy         <= 1'b0;
      x_pos        <= '0;
      y_pos        <= '0;
      btn          <= '0;
      sample_valid <= 1'b0;
      led_ack      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      led_ack      <= 1'b0;

      // A tick on the same edge that IDLE consumes the pending one simply
      // becomes the new pending tick; only a genuinely stacked tick overruns.
      if (tick) begin
        if (tick_pend && !start) overrun <= 1'b1;
        tick_pend <= 1'b1;
      end else if (start) begin
        tick_pend <= 1'b0;
      end

      // A request landing on the start edge is not part of this transaction
      // (din is latched from the old shadow), so it stays pending.
      if (led_req) begin
        led_shadow <= led_val;
        led_pend   <= 1'b1;
      end else if (start) begin
        led_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            din       <= {LED_CMD_PFX, led_shadow};
            carry_ack <= led_pend;
            snd_rec   <= 1'b1;
            busy      <= 1'b1;
            tmr       <= HOLD_LD;
          end
        end
        SEND: begin
          if (tmr == '0) begin
            state   <= WAIT;
            snd_rec <= 1'b0;
            tmr     <= XFER_LD;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        WAIT: begin
          // dout is sampled on the edge that enters CAPTURE so the decoded
          // sample and its strobes are already valid during CAPTURE.
          if (tmr == '0) begin
            state        <= CAPTURE;
            x_pos        <= x_field(dout);
            y_pos        <= y_field(dout);
            btn          <= btn_field(dout);
            sample_valid <= 1'b1;
            led_ack      <= carry_ack;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        CAPTURE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          carry_ack <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          snd_rec <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
